// File: rtl/pl_hazard_ctrl.sv
// Pipeline control for the 5-stage MIPS core: stalls, bubbles, flushes,
// operand forwarding, post-reset fill, debug halt/drain and event counters.
module pl_hazard_ctrl #(
    parameter int INIT_CYCLES = 3,
    parameter int DELAY_SLOT  = 1,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [4:0]    drs,
    input  logic [4:0]    drt,
    input  logic          d_use_rs,
    input  logic          d_use_rt,
    input  logic          d_branch_taken,
    input  logic [4:0]    ern,
    input  logic          ewreg,
    input  logic          em2reg,
    input  logic [4:0]    mrn,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic          halt_req,
    output logic          wpc,
    output logic          wir,
    output logic          dbubble,
    output logic          iflush,
    output logic [1:0]    fwda,
    output logic [1:0]    fwdb,
    output logic          halted,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [3:0] INIT_LOAD = 4'(INIT_CYCLES - 1);
    localparam logic [1:0] DRAIN_LOAD = 2'd2;
    localparam bit FLUSH_EN = (DELAY_SLOT == 0);

    state_t        r_state;
    state_t        w_state_nx;
    logic [3:0]    r_init_cnt;
    logic [3:0]    w_init_cnt_nx;
    logic [1:0]    r_drain_cnt;
    logic [1:0]    w_drain_cnt_nx;
    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] r_flush_cnt;

    logic w_lu;
    logic w_stall_ev;
    logic w_flush_ev;

    // EX results win over MEM; a load still in EX can never be forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] e_rn,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] m_rn,
        input logic       m_wreg,
        input logic       m_m2reg
    );
        logic hit_e;
        logic hit_m;
        hit_e = e_wreg && (e_rn != 5'd0) && (e_rn == r);
        hit_m = m_wreg && (m_rn != 5'd0) && (m_rn == r);
        if (hit_e && !e_m2reg)
            return 2'd1;
        else if (hit_m && !m_m2reg)
            return 2'd2;
        else if (hit_m && m_m2reg)
            return 2'd3;
        else
            return 2'd0;
    endfunction

    always_comb begin
        fwda = fwd_sel(drs, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
        fwdb = fwd_sel(drt, ern, ewreg, em2reg, mrn, mwreg, mm2reg);
    end

    always_comb begin
        w_lu = ewreg && em2reg && (ern != 5'd0) &&
               ((d_use_rs && (ern == drs)) ||
                (d_use_rt && (ern == drt)));
    end

    always_comb begin
        w_state_nx     = r_state;
        w_init_cnt_nx  = r_init_cnt;
        w_drain_cnt_nx = r_drain_cnt;
        wpc            = 1'b0;
        wir            = 1'b0;
        dbubble        = 1'b1;
        iflush         = 1'b0;
        halted         = 1'b0;
        w_stall_ev     = 1'b0;
        w_flush_ev     = 1'b0;
        unique case (r_state)
            S_INIT: begin
                if (r_init_cnt == 4'd0)
                    w_state_nx = S_RUN;
                else
                    w_init_cnt_nx = r_init_cnt - 4'd1;
            end
            S_RUN: begin
                if (w_lu) begin
                    w_stall_ev = 1'b1;
                end else begin
                    wpc        = 1'b1;
                    wir        = 1'b1;
                    dbubble    = 1'b0;
                    iflush     = d_branch_taken && FLUSH_EN;
                    w_flush_ev = iflush;
                end
                if (halt_req) begin
                    w_state_nx     = S_DRAIN;
                    w_drain_cnt_nx = DRAIN_LOAD;
                end
            end
            // Three bubble cycles empty EX, MEM and WB.
            S_DRAIN: begin
                if (r_drain_cnt == 2'd0)
                    w_state_nx = S_HALTED;
                else
                    w_drain_cnt_nx = r_drain_cnt - 2'd1;
            end
            S_HALTED: begin
                halted = 1'b1;
                if (!halt_req)
                    w_state_nx = S_RUN;
            end
            default: begin
                w_state_nx = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state     <= S_INIT;
            r_init_cnt  <= INIT_LOAD;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nx;
            r_init_cnt  <= w_init_cnt_nx;
            r_drain_cnt <= w_drain_cnt_nx;
        end
    end

    // Saturating counters: stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_ev && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush_ev && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pl_hazard_ctrl.sv
// Directed vector bench for pl_hazard_ctrl: fill, forwarding, load-use,
// branch flush, halt/drain/resume, counter saturation and async reset.
module tb_pl_hazard_ctrl;

    localparam int CW = 4;

    logic          clk;
    logic          clrn;
    logic [4:0]    drs, drt, ern, mrn;
    logic          d_use_rs, d_use_rt, d_branch_taken;
    logic          ewreg, em2reg, mwreg, mm2reg, halt_req;
    logic          wpc, wir, dbubble, iflush, halted;
    logic [1:0]    fwda, fwdb;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic          wpc2, wir2, dbubble2, iflush2, halted2;
    logic [1:0]    fwda2, fwdb2;
    logic [CW-1:0] stall_cnt2, flush_cnt2;

    int n_vec;
    int n_err;

    pl_hazard_ctrl #(.INIT_CYCLES(3), .DELAY_SLOT(0), .CW(CW)) dut (
        .clk(clk), .clrn(clrn),
        .drs(drs), .drt(drt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_branch_taken(d_branch_taken),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .halt_req(halt_req),
        .wpc(wpc), .wir(wir), .dbubble(dbubble), .iflush(iflush),
        .fwda(fwda), .fwdb(fwdb), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pl_hazard_ctrl #(.INIT_CYCLES(3), .DELAY_SLOT(1), .CW(CW)) dut_ds (
        .clk(clk), .clrn(clrn),
        .drs(drs), .drt(drt),
        .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_branch_taken(d_branch_taken),
        .ern(ern), .ewreg(ewreg), .em2reg(em2reg),
        .mrn(mrn), .mwreg(mwreg), .mm2reg(mm2reg),
        .halt_req(halt_req),
        .wpc(wpc2), .wir(wir2), .dbubble(dbubble2), .iflush(iflush2),
        .fwda(fwda2), .fwdb(fwdb2), .halted(halted2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [4:0] drs, drt;
        logic       use_rs, use_rt, bt;
        logic [4:0] ern;
        logic       ewreg, em2reg;
        logic [4:0] mrn;
        logic       mwreg, mm2reg;
        logic       x_wpc, x_wir, x_db, x_fl;
        logic [1:0] x_fa, x_fb;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        drs = 0; drt = 0; d_use_rs = 0; d_use_rt = 0;
        d_branch_taken = 0;
        ern = 0; ewreg = 0; em2reg = 0;
        mrn = 0; mwreg = 0; mm2reg = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Releases reset at a falling edge and checks the three fill cycles.
    task automatic release_and_fill(input string tag);
        clrn = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk({tag, "_wpc"}, int'(wpc), (i == 3) ? 1 : 0);
            chk({tag, "_db"}, int'(dbubble), (i == 3) ? 0 : 1);
        end
    endtask

    vec_t vt[12];
    int   x_stalls;
    int   x_flushes;

    initial begin
        n_vec = 0;
        n_err = 0;
        vt[0]  = '{"idle",     0,0,0,0,0, 0,0,0, 0,0,0, 1,1,0,0, 0,0};
        vt[1]  = '{"lu_rs",    5,0,1,0,0, 5,1,1, 0,0,0, 0,0,1,0, 0,0};
        vt[2]  = '{"lu_fwd3",  5,0,1,0,0, 0,0,0, 5,1,1, 1,1,0,0, 3,0};
        vt[3]  = '{"fwd_ex",   7,7,1,1,0, 7,1,0, 7,1,0, 1,1,0,0, 1,1};
        vt[4]  = '{"fwd_mem",  7,7,1,1,0, 7,0,0, 7,1,0, 1,1,0,0, 2,2};
        vt[5]  = '{"fwd_r0",   0,0,1,1,0, 0,1,0, 0,1,0, 1,1,0,0, 0,0};
        vt[6]  = '{"br_flush", 0,0,0,0,1, 0,0,0, 0,0,0, 1,1,0,1, 0,0};
        vt[7]  = '{"br_lu",    0,9,0,1,1, 9,1,1, 0,0,0, 0,0,1,0, 0,0};
        vt[8]  = '{"lu_nouse", 5,0,0,0,0, 5,1,1, 0,0,0, 1,1,0,0, 0,0};
        vt[9]  = '{"fwd_mix",  3,4,1,1,0, 3,1,0, 4,1,1, 1,1,0,0, 1,3};
        vt[10] = '{"fwd_prio", 6,6,1,1,0, 6,1,0, 6,1,1, 1,1,0,0, 1,1};
        vt[11] = '{"fwd_nomw", 8,8,1,1,0, 0,0,0, 8,0,0, 1,1,0,0, 0,0};

        clrn = 1'b0;
        halt_req = 1'b0;
        idle_inputs();
        #12;
        @(negedge clk);
        chk("rst_wpc", int'(wpc), 0);
        chk("rst_wir", int'(wir), 0);
        chk("rst_db", int'(dbubble), 1);
        chk("rst_iflush", int'(iflush), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_stall", int'(stall_cnt), 0);
        chk("rst_flush", int'(flush_cnt), 0);
        chk("rst_fwda", int'(fwda), 0);
        chk("rst_fwdb", int'(fwdb), 0);
        release_and_fill("init");

        x_stalls = 0;
        x_flushes = 0;
        for (int i = 0; i < 12; i++) begin
            drs = vt[i].drs; drt = vt[i].drt;
            d_use_rs = vt[i].use_rs; d_use_rt = vt[i].use_rt;
            d_branch_taken = vt[i].bt;
            ern = vt[i].ern; ewreg = vt[i].ewreg;
            em2reg = vt[i].em2reg;
            mrn = vt[i].mrn; mwreg = vt[i].mwreg;
            mm2reg = vt[i].mm2reg;
            #1;
            chk({vt[i].name, "_wpc"}, int'(wpc), int'(vt[i].x_wpc));
            chk({vt[i].name, "_wir"}, int'(wir), int'(vt[i].x_wir));
            chk({vt[i].name, "_db"}, int'(dbubble), int'(vt[i].x_db));
            chk({vt[i].name, "_iflush"}, int'(iflush), int'(vt[i].x_fl));
            chk({vt[i].name, "_fwda"}, int'(fwda), int'(vt[i].x_fa));
            chk({vt[i].name, "_fwdb"}, int'(fwdb), int'(vt[i].x_fb));
            chk({vt[i].name, "_ds_iflush"}, int'(iflush2), 0);
            if (vt[i].x_db) x_stalls++;
            if (vt[i].x_fl) x_flushes++;
            tick();
        end
        idle_inputs();
        #1;
        chk("tbl_stall_cnt", int'(stall_cnt), x_stalls);
        chk("tbl_flush_cnt", int'(flush_cnt), x_flushes);
        chk("ds_flush_cnt", int'(flush_cnt2), 0);

        // One-cycle halt pulse: 3 drain cycles, 1 halted cycle, resume.
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_db", int'(dbubble), 1);
            chk("drain_wpc", int'(wpc), 0);
            chk("drain_halted", int'(halted), 0);
            tick();
        end
        chk("halt_pulse_halted", int'(halted), 1);
        chk("halt_pulse_wpc", int'(wpc), 0);
        tick();
        chk("resume_halted", int'(halted), 0);
        chk("resume_wpc", int'(wpc), 1);

        // Held halt stays frozen until released.
        halt_req = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 4; i++) begin
            chk("halt_hold", int'(halted), 1);
            tick();
        end
        halt_req = 1'b0;
        tick();
        chk("halt_release", int'(halted), 0);
        chk("halt_release_wpc", int'(wpc), 1);
        chk("halt_keep_stall", int'(stall_cnt), x_stalls);

        // Reset in HALTED clears everything immediately.
        halt_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("pre_rst_halted", int'(halted), 1);
        clrn = 1'b0;
        #1;
        chk("rst_halt_halted", int'(halted), 0);
        chk("rst_halt_stall", int'(stall_cnt), 0);
        chk("rst_halt_flush", int'(flush_cnt), 0);
        halt_req = 1'b0;
        @(negedge clk);
        release_and_fill("refill");

        // Saturate stall_cnt with back-to-back load-use stalls.
        drs = 5'd5; d_use_rs = 1'b1;
        ern = 5'd5; ewreg = 1'b1; em2reg = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 14) chk("sat_pre", int'(stall_cnt), 14);
            tick();
        end
        chk("sat_stall_cnt", int'(stall_cnt), 15);
        chk("sat_wpc", int'(wpc), 0);
        idle_inputs();

        // Reset pulse mid-DRAIN returns to INIT with counters cleared.
        halt_req = 1'b1;
        tick();
        tick();
        chk("mid_drain_db", int'(dbubble), 1);
        clrn = 1'b0;
        #1;
        chk("drain_rst_stall", int'(stall_cnt), 0);
        chk("drain_rst_wpc", int'(wpc), 0);
        chk("drain_rst_halted", int'(halted), 0);
        halt_req = 1'b0;
        @(negedge clk);
        release_and_fill("drain_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pl_hazard_ctrl.md
# pl_hazard_ctrl

Pipeline control unit for the 5-stage MIPS core. It drives the PC and IF/ID write enables, inserts bubbles into ID/EX, flushes IF/ID on taken branches, and produces the A/B operand forwarding selects for the ID stage. It also sequences the pipeline through a post-reset fill period and a debug halt/drain/resume cycle, and keeps saturating stall and flush event counters.

## Interface
Parameters:
- INIT_CYCLES, 3: cycles after reset release during which the pipeline is held and filled with bubbles (1..15).
- DELAY_SLOT, 1: 1 means the branch delay slot executes and iflush is never asserted; 0 means a taken branch flushes IF/ID.
- CW, 16: width of the event counters.

Ports:
- clk  in  1  Clock. All state updates on the rising edge.
- clrn  in  1  Reset, asynchronous, active-low.
- drs, drt  in  5  Source register numbers of the instruction in ID.
- d_use_rs, d_use_rt  in  1  The ID instruction reads rs / rt.
- d_branch_taken  in  1  Branch or jump in ID resolved as taken.
- ern, ewreg, em2reg  in  5/1/1  EX-stage destination, write-enable and load flag.
- mrn, mwreg, mm2reg  in  5/1/1  MEM-stage destination, write-enable and load flag.
- halt_req  in  1  Level request to halt the pipeline.
- wpc  out  1  PC write enable.
- wir  out  1  IF/ID write enable.
- dbubble  out  1  Forces the control fields written into ID/EX (dwreg, dm2reg, dwmem, djal) to 0.
- iflush  out  1  Loads a NOP into IF/ID on the next edge.
- fwda, fwdb  out  2  Operand select: 0 register file, 1 EX ALU result, 2 MEM ALU result, 3 MEM load data.
- halted  out  1  Pipeline is drained and frozen.
- stall_cnt, flush_cnt  out  CW  Saturating event counters.

## Operation
- FSM states: INIT, RUN, DRAIN, HALTED. Registered state: the FSM state, a 4-bit init counter, a 2-bit drain counter, and the two event counters. All other outputs are combinational from the inputs and the registered state.
- Matching rules:
  - hitE(r) = ewreg & (ern != 0) & (ern == r).
  - hitM(r) = mwreg & (mrn != 0) & (mrn == r).
- Forwarding. fwda for drs, and fwdb for drt with the same rule:
  - hitE & ~em2reg gives 1.
  - Otherwise hitM & ~mm2reg gives 2.
  - Otherwise hitM & mm2reg gives 3.
  - Otherwise 0.
  - The EX stage has priority over MEM.
  - Forwarding selects are computed in every state.
- Load-use stall: lu = ewreg & em2reg & (ern != 0) & ((d_use_rs & ern == drs) | (d_use_rt & ern == drt)).
- INIT:
  - Outputs: wpc = 0, wir = 0, dbubble = 1, iflush = 0.
  - The counter loads INIT_CYCLES - 1 on reset and decrements each cycle. When it reaches 0, the next state is RUN.
- RUN:
  - If lu: wpc = 0, wir = 0, dbubble = 1, iflush = 0, and stall_cnt increments.
  - Else: wpc = 1, wir = 1, dbubble = 0. iflush = d_branch_taken & (DELAY_SLOT == 0), and flush_cnt increments when iflush = 1.
  - If halt_req = 1, the next state is DRAIN (drain counter = 2). This is accepted even during lu.
- DRAIN:
  - Outputs: wpc = 0, wir = 0, dbubble = 1, iflush = 0. The ID instruction and PC are held and re-issue on resume.
  - Drain runs exactly 3 cycles to push out EX, MEM and WB, then goes to HALTED regardless of halt_req.
- HALTED:
  - Outputs: halted = 1, wpc = 0, wir = 0, dbubble = 1, iflush = 0.
  - If halt_req = 0, the next state is RUN. Otherwise it stays in HALTED.
- Counters saturate at all-ones and do not wrap. They are not cleared by halt.

## Timing
- Reset (clrn = 0, asynchronous) forces:
  - state = INIT and init counter = INIT_CYCLES - 1.
  - stall_cnt = flush_cnt = 0, halted = 0.
  - wpc = 0, wir = 0, dbubble = 1, iflush = 0.
  - fwda and fwdb follow the inputs combinationally (0 when the inputs are idle).
- Reset release: the first RUN cycle, with wpc = 1, is cycle INIT_CYCLES after the first clk edge with clrn = 1.
- Load-use: exactly one bubble per load. On the following cycle the load is in MEM and fwd = 3 resolves the dependency with no second stall.
- Forwarding selects have zero latency: they are valid in the same cycle the ID/EX/MEM fields are valid.
- Halt latency: halt_req sampled at edge N gives DRAIN for cycles N+1..N+3 and halted = 1 from cycle N+4.
- Resume latency: halt_req = 0 sampled in HALTED gives RUN in the next cycle.
- Reset asserted mid-DRAIN or mid-HALTED returns immediately to INIT. The counters clear.

## Test plan
- Reset with INIT_CYCLES = 3, then release -> wpc = 0 for 3 cycles, wpc = 1 on the 4th; both counters are 0.
- lw $5 in EX (ewreg = 1, em2reg = 1, ern = 5) and ID add using rs = 5 -> one cycle with wpc = wir = 0 and dbubble = 1, stall_cnt = 1. The next cycle has fwda = 3 and no stall.
- ern = mrn = 7, ewreg = mwreg = 1, em2reg = 0, drs = drt = 7 -> fwda = fwdb = 1. With ewreg = 0 -> fwda = fwdb = 2. With ern = 0, or a match on register 0 -> fwd = 0.
- DELAY_SLOT = 0, d_branch_taken = 1 in RUN without lu -> iflush = 1 for one cycle and flush_cnt = 1. DELAY_SLOT = 1 -> iflush stays 0.
- halt_req pulsed for 1 cycle in RUN -> 3 DRAIN cycles with dbubble = 1, one HALTED cycle with halted = 1, then RUN. halt_req held -> halted stays 1.
- Force stall_cnt to its all-ones value via 2^CW stalls (CW = 4 for the bench) -> it holds at 15. A clrn pulse mid-DRAIN -> INIT, with counters at 0.
